// File: rtl/lvt_multi_port_ram.sv
// -----------------------------------------------------------------------------
// lvt_multi_port_ram
//
// Multi-ported RAM built from one storage bank per write port plus a live
// value table (LVT).  The LVT records which bank holds the most recent value
// for each address, so every read port looks up the LVT and then selects
// that bank.  Read data is registered, so the read latency is one cycle.
//
// Optional feature (macro LVT_RAM_INIT_CLEAR_EN): a post-reset clear
// sequencer zeroes bank 0 and the LVT one address per cycle.  While it runs,
// user writes are ignored and reads return 0.  Without the macro,
// init_busy_o is tied low and contents are undefined until written.
//
// Ports
//   clk          single clock for all ports
//   a_rst_n      asynchronous active-low reset (clears read data and
//                conflict flag only; bank contents are kept)
//   en_w_i       per-write-port enable
//   waddr_i      per-write-port address (out-of-range writes are dropped)
//   data_i       per-write-port data
//   en_r_i       per-read-port enable (disabled ports hold data_o)
//   raddr_i      per-read-port address (out-of-range reads return 0)
//   data_o       registered read data
//   conflict_o   one-cycle pulse: two or more enabled writes hit the same
//                address on the previous edge
//   init_busy_o  high while the clear sequencer runs
// -----------------------------------------------------------------------------
module lvt_multi_port_ram #(
  parameter int    DATA_DEPTH = 128,
  parameter int    DATA_WIDTH = 64,
  parameter int    RPORTS_NUM = 4,
  parameter int    WPORTS_NUM = 4,
  parameter string WRITE_MODE = "write_first",
  localparam int   ADDR_WIDTH = $clog2(DATA_DEPTH),
  localparam int   LVT_WIDTH  = (WPORTS_NUM > 1) ? $clog2(WPORTS_NUM) : 1
) (
  input  logic                                   clk,
  input  logic                                   a_rst_n,
  input  logic [WPORTS_NUM-1:0]                  en_w_i,
  input  logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0]  waddr_i,
  input  logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0]  data_i,
  input  logic [RPORTS_NUM-1:0]                  en_r_i,
  input  logic [RPORTS_NUM-1:0][ADDR_WIDTH-1:0]  raddr_i,
  output logic [RPORTS_NUM-1:0][DATA_WIDTH-1:0]  data_o,
  output logic                                   conflict_o,
  output logic                                   init_busy_o
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W     = (ADDR_WIDTH+1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);
  localparam bit                    WRITE_FIRST = (WRITE_MODE == "write_first");

  if ((WRITE_MODE != "write_first") && (WRITE_MODE != "read_first")) begin : g_bad_mode
    $error("lvt_multi_port_ram: WRITE_MODE must be write_first or read_first");
  end

  // True when the address lies inside the array (depth need not be 2^n).
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  logic [DATA_WIDTH-1:0] bank_r [WPORTS_NUM][DATA_DEPTH];
  logic [LVT_WIDTH-1:0]  lvt_sel_s [RPORTS_NUM];
  logic [ADDR_WIDTH-1:0] rd_idx_s  [RPORTS_NUM];
  logic [WPORTS_NUM-1:0] user_we_s;
  logic [RPORTS_NUM-1:0][DATA_WIDTH-1:0] rd_next_s;
  logic [RPORTS_NUM-1:0][DATA_WIDTH-1:0] data_r;
  logic                  conflict_s;
  logic                  conflict_r;
  logic                  clear_active_s;
  logic [ADDR_WIDTH-1:0] clr_addr_s;

`ifdef LVT_RAM_INIT_CLEAR_EN
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_e;

  clr_state_e            state_r;
  clr_state_e            state_next_s;
  logic [ADDR_WIDTH-1:0] clr_addr_r;
  logic [ADDR_WIDTH-1:0] clr_addr_next_s;

  // Clear sequencer state and address registers; reset restarts at address 0.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_r    <= ST_CLEAR;
      clr_addr_r <= '0;
    end else begin
      state_r    <= state_next_s;
      clr_addr_r <= clr_addr_next_s;
    end
  end

  // Clear sequencer next-state: one address per cycle, then idle.
  always_comb begin
    state_next_s    = state_r;
    clr_addr_next_s = clr_addr_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_addr_r == LAST_ADDR) begin
          state_next_s    = ST_IDLE;
          clr_addr_next_s = '0;
        end else begin
          clr_addr_next_s = clr_addr_r + ADDR_ONE;
        end
      end
      ST_IDLE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s    = ST_CLEAR;
        clr_addr_next_s = '0;
      end
    endcase
  end

  assign clear_active_s = (state_r == ST_CLEAR);
  assign clr_addr_s     = clr_addr_r;
  assign init_busy_o    = clear_active_s;
`else
  assign clear_active_s = 1'b0;
  assign clr_addr_s     = '0;
  assign init_busy_o    = 1'b0;
`endif

  // Qualified write enables and same-address collision detection.
  always_comb begin
    conflict_s = 1'b0;
    for (int k = 0; k < WPORTS_NUM; k++) begin
      user_we_s[k] = en_w_i[k] && addr_ok(waddr_i[k]) && !clear_active_s;
    end
    for (int i = 0; i < WPORTS_NUM; i++) begin
      for (int j = i + 1; j < WPORTS_NUM; j++) begin
        if (user_we_s[i] && user_we_s[j] && (waddr_i[i] == waddr_i[j])) begin
          conflict_s = 1'b1;
        end else begin
          conflict_s = conflict_s;
        end
      end
    end
  end

  // Bank writes; storage is deliberately left untouched by reset, and no
  // write happens on an edge that sees reset asserted.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
    end else if (clear_active_s) begin
      bank_r[0][clr_addr_s] <= '0;
    end else begin
      for (int k = 0; k < WPORTS_NUM; k++) begin
        if (user_we_s[k]) begin
          bank_r[k][waddr_i[k]] <= data_i[k];
        end
      end
    end
  end

  if (WPORTS_NUM > 1) begin : g_lvt
    logic [LVT_WIDTH-1:0] lvt_r [DATA_DEPTH];

    // LVT update; ascending port order lets the highest colliding port win.
    always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
      end else if (clear_active_s) begin
        lvt_r[clr_addr_s] <= '0;
      end else begin
        for (int k = 0; k < WPORTS_NUM; k++) begin
          if (user_we_s[k]) begin
            lvt_r[waddr_i[k]] <= LVT_WIDTH'(k);
          end
        end
      end
    end

    // LVT lookup per read port.
    always_comb begin
      for (int r = 0; r < RPORTS_NUM; r++) begin
        lvt_sel_s[r] = lvt_r[rd_idx_s[r]];
      end
    end
  end else begin : g_no_lvt
    // Single bank: the table is a constant 0.
    always_comb begin
      for (int r = 0; r < RPORTS_NUM; r++) begin
        lvt_sel_s[r] = '0;
      end
    end
  end

  // Next read data: bank selected by LVT, optional same-cycle write bypass.
  always_comb begin
    for (int r = 0; r < RPORTS_NUM; r++) begin
      rd_idx_s[r]  = addr_ok(raddr_i[r]) ? raddr_i[r] : '0;
      rd_next_s[r] = '0;
      if (!clear_active_s && addr_ok(raddr_i[r])) begin
        rd_next_s[r] = bank_r[lvt_sel_s[r]][rd_idx_s[r]];
        if (WRITE_FIRST) begin
          for (int k = 0; k < WPORTS_NUM; k++) begin
            if (user_we_s[k] && (waddr_i[k] == raddr_i[r])) begin
              rd_next_s[r] = data_i[k];
            end else begin
              rd_next_s[r] = rd_next_s[r];
            end
          end
        end else begin
          rd_next_s[r] = rd_next_s[r];
        end
      end else begin
        rd_next_s[r] = '0;
      end
    end
  end

  // Registered read data and conflict pulse, cleared asynchronously.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      data_r     <= '0;
      conflict_r <= 1'b0;
    end else begin
      conflict_r <= conflict_s;
      for (int r = 0; r < RPORTS_NUM; r++) begin
        if (en_r_i[r]) begin
          data_r[r] <= rd_next_s[r];
        end
      end
    end
  end

  assign data_o     = data_r;
  assign conflict_o = conflict_r;

endmodule

// File: tb/tb_lvt_multi_port_ram.sv
// -----------------------------------------------------------------------------
// tb_lvt_multi_port_ram
//
// Directed bench for lvt_multi_port_ram.  Two instances share all inputs:
// one in write_first mode, one in read_first mode.  The default build uses a
// non-power-of-two depth (100) so out-of-range addresses can be driven; with
// LVT_RAM_INIT_CLEAR_EN the depth is 16 and the clear sequencer is exercised.
// -----------------------------------------------------------------------------
module tb_lvt_multi_port_ram;

`ifdef LVT_RAM_INIT_CLEAR_EN
  localparam int   DEPTH    = 16;
  localparam logic BUSY_RST = 1'b1;
`else
  localparam int   DEPTH    = 100;
  localparam logic BUSY_RST = 1'b0;
`endif
  localparam int DW = 64;
  localparam int RP = 4;
  localparam int WP = 4;
  localparam int AW = $clog2(DEPTH);

  logic                   clk = 1'b0;
  logic                   a_rst_n;
  logic [WP-1:0]          en_w;
  logic [WP-1:0][AW-1:0]  waddr;
  logic [WP-1:0][DW-1:0]  data_in;
  logic [RP-1:0]          en_r;
  logic [RP-1:0][AW-1:0]  raddr;
  logic [RP-1:0][DW-1:0]  data_wf;
  logic [RP-1:0][DW-1:0]  data_rf;
  logic                   conflict_wf;
  logic                   conflict_rf;
  logic                   busy_wf;
  logic                   busy_rf;

  int errors = 0;
  int checks = 0;
  int cnt;

  lvt_multi_port_ram #(
    .DATA_DEPTH(DEPTH), .DATA_WIDTH(DW), .RPORTS_NUM(RP), .WPORTS_NUM(WP),
    .WRITE_MODE("write_first")
  ) dut_wf (
    .clk(clk), .a_rst_n(a_rst_n), .en_w_i(en_w), .waddr_i(waddr),
    .data_i(data_in), .en_r_i(en_r), .raddr_i(raddr), .data_o(data_wf),
    .conflict_o(conflict_wf), .init_busy_o(busy_wf)
  );

  lvt_multi_port_ram #(
    .DATA_DEPTH(DEPTH), .DATA_WIDTH(DW), .RPORTS_NUM(RP), .WPORTS_NUM(WP),
    .WRITE_MODE("read_first")
  ) dut_rf (
    .clk(clk), .a_rst_n(a_rst_n), .en_w_i(en_w), .waddr_i(waddr),
    .data_i(data_in), .en_r_i(en_r), .raddr_i(raddr), .data_o(data_rf),
    .conflict_o(conflict_rf), .init_busy_o(busy_rf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_w    = '0;
    waddr   = '0;
    data_in = '0;
    en_r    = '0;
    raddr   = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst_n = 1'b0;
    idle();
    repeat (2) tick();
    check("rst_data_wf", data_wf[0], 64'h0);
    check("rst_data_rf", data_rf[3], 64'h0);
    check("rst_conflict", 64'(conflict_wf), 64'h0);
    check("rst_busy", 64'(busy_wf), 64'(BUSY_RST));

`ifdef LVT_RAM_INIT_CLEAR_EN
    // Start a clear, attempt a write, then reset part-way through.
    a_rst_n = 1'b1;
    en_w[0] = 1'b1; waddr[0] = AW'(5); data_in[0] = 64'h55;
    tick();
    idle();
    repeat (7) tick();
    check("busy_at_8", 64'(busy_rf), 64'h1);
    a_rst_n = 1'b0;
    tick();
    a_rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && busy_wf; i++) begin
      if (i == 11) begin
        en_w[1] = 1'b1; waddr[1] = AW'(2); data_in[1] = 64'h5A;
        en_r[0] = 1'b1; raddr[0] = AW'(2);
      end else begin
        idle();
      end
      tick();
      cnt++;
      if (i == 11) check("read_in_clear", data_wf[0], 64'h0);
    end
    check("clear_cycles", 64'(cnt), 64'd16);
    idle();
    en_r = '1;
    raddr[0] = AW'(0); raddr[1] = AW'(2); raddr[2] = AW'(5); raddr[3] = AW'(15);
    tick();
    check("clr_rd0", data_wf[0], 64'h0);
    check("clr_rd2_ignored_wr", data_wf[1], 64'h0);
    check("clr_rd5", data_rf[2], 64'h0);
    check("clr_rd15", data_wf[3], 64'h0);
    idle();
`else
    a_rst_n = 1'b1;
    tick();
`endif

    // Basic write then read.
    en_w[0] = 1'b1; waddr[0] = AW'(3); data_in[0] = 64'hA5;
    tick();
    check("no_conflict_single", 64'(conflict_wf), 64'h0);
    idle();
    en_r[0] = 1'b1; raddr[0] = AW'(3);
    tick();
    check("rd3_wf", data_wf[0], 64'hA5);
    check("rd3_rf", data_rf[0], 64'hA5);

    // Two ports to one address: conflict pulse, highest port wins.
    idle();
    en_w[1] = 1'b1; waddr[1] = AW'(5); data_in[1] = 64'h11;
    en_w[3] = 1'b1; waddr[3] = AW'(5); data_in[3] = 64'h33;
    tick();
    check("conflict_wf", 64'(conflict_wf), 64'h1);
    check("conflict_rf", 64'(conflict_rf), 64'h1);
    idle();
    tick();
    check("conflict_drop", 64'(conflict_wf), 64'h0);
    en_r[2] = 1'b1; raddr[2] = AW'(5);
    tick();
    check("rd5_winner_wf", data_wf[2], 64'h33);
    check("rd5_winner_rf", data_rf[2], 64'h33);
    check("hold_port0", data_wf[0], 64'hA5);

    // Same-cycle read/write collision policy.
    idle();
    en_w[0] = 1'b1; waddr[0] = AW'(9); data_in[0] = 64'h10;
    tick();
    idle();
    en_w[2] = 1'b1; waddr[2] = AW'(9); data_in[2] = 64'h77;
    en_r[1] = 1'b1; raddr[1] = AW'(9);
    tick();
    check("coll_write_first", data_wf[1], 64'h77);
    check("coll_read_first", data_rf[1], 64'h10);
    idle();
    en_r[1] = 1'b1; raddr[1] = AW'(9);
    tick();
    check("reread_rf", data_rf[1], 64'h77);
    check("reread_wf", data_wf[1], 64'h77);

    // Every read port, every write port, distinct addresses.
    idle();
    for (int k = 0; k < WP; k++) begin
      en_w[k]    = 1'b1;
      waddr[k]   = AW'(10 + k);
      data_in[k] = 64'h100 * 64'(k + 1) + 64'(k);
    end
    tick();
    idle();
    en_r = '1;
    raddr[0] = AW'(13); raddr[1] = AW'(12); raddr[2] = AW'(11); raddr[3] = AW'(10);
    tick();
    check("all_r0", data_wf[0], 64'h403);
    check("all_r1", data_rf[1], 64'h302);
    check("all_r2", data_wf[2], 64'h201);
    check("all_r3", data_rf[3], 64'h100);

    // Collision plus same-cycle read in write_first: highest port bypassed.
    idle();
    en_w[0] = 1'b1; waddr[0] = AW'(7); data_in[0] = 64'hAA;
    en_w[2] = 1'b1; waddr[2] = AW'(7); data_in[2] = 64'hBB;
    en_r[0] = 1'b1; raddr[0] = AW'(7);
    tick();
    check("bypass_winner", data_wf[0], 64'hBB);
    check("conflict_02", 64'(conflict_wf), 64'h1);
    idle();
    en_r[0] = 1'b1; raddr[0] = AW'(7);
    tick();
    check("rd7_rf", data_rf[0], 64'hBB);

`ifndef LVT_RAM_INIT_CLEAR_EN
    // Out-of-range addresses and the last valid address.
    idle();
    en_w[1] = 1'b1; waddr[1] = AW'(120); data_in[1] = 64'hDEAD;
    en_w[2] = 1'b1; waddr[2] = AW'(120); data_in[2] = 64'hBEEF;
    en_w[3] = 1'b1; waddr[3] = AW'(99);  data_in[3] = 64'h99;
    en_r[3] = 1'b1; raddr[3] = AW'(120);
    tick();
    check("oor_no_conflict", 64'(conflict_wf), 64'h0);
    check("oor_bypass_zero", data_wf[3], 64'h0);
    idle();
    en_r[2] = 1'b1; raddr[2] = AW'(99);
    en_r[3] = 1'b1; raddr[3] = AW'(120);
    tick();
    check("rd_last_addr", data_wf[2], 64'h99);
    check("oor_read_zero", data_rf[3], 64'h0);
`endif

    // Reset mid-operation: asynchronous clear of outputs, no write in reset.
    idle();
    en_w[0] = 1'b1; waddr[0] = AW'(14); data_in[0] = 64'h1;
    en_w[1] = 1'b1; waddr[1] = AW'(14); data_in[1] = 64'h2;
    en_r[0] = 1'b1; raddr[0] = AW'(3);
    tick();
    check("pre_rst_data", data_wf[0], 64'hA5);
    check("pre_rst_conflict", 64'(conflict_rf), 64'h1);
    #2;
    a_rst_n = 1'b0;
    #1;
    check("async_rst_data_wf", data_wf[0], 64'h0);
    check("async_rst_data_rf", data_rf[0], 64'h0);
    check("async_rst_conflict", 64'(conflict_wf), 64'h0);
    idle();
    en_w[0] = 1'b1; waddr[0] = AW'(3); data_in[0] = 64'hFF;
    en_r[0] = 1'b1; raddr[0] = AW'(3);
    tick();
    tick();
    check("rd_blocked_in_rst", data_wf[0], 64'h0);
    idle();
    a_rst_n = 1'b1;
`ifdef LVT_RAM_INIT_CLEAR_EN
    check("busy_after_rst", 64'(busy_wf), 64'h1);
`else
    en_r[0] = 1'b1; raddr[0] = AW'(3);
    tick();
    check("no_write_in_rst", data_wf[0], 64'hA5);
    check("rf_no_write_in_rst", data_rf[0], 64'hA5);
`endif
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
